step_request_queue: RTL and testbench
=====================================

# step_request_queue

Consumes the single-cycle edge pulses produced by the input conditioner (synchronizer + edge detector) and turns them into a queued request/acknowledge handshake toward the executor core. Each accepted edge becomes exactly one `req`/`ack` transaction. A programmable lockout window after each accepted edge rejects contact bounce. Edges arriving faster than the core consumes them are counted as pending, saturating with a sticky overflow flag.

## Interface
- `DEPTH_W`, default 4: width of the pending counter; maximum pending = 2^DEPTH_W − 1.
- `LOCKOUT`, default 1000: lockout length in clk cycles after an accepted edge; 0 disables lockout.
- `LOCKOUT_W`, default 16: width of the lockout counter; must satisfy LOCKOUT < 2^LOCKOUT_W.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `edge_in`  in  1  one-cycle pulse from the conditioner's `output_edge`, synchronous to clk.
- `clear`  in  1  synchronous clear of the pending count, overflow, lockout and handshake.
- `req`  out  1  registered request to the executor core.
- `ack`  in  1  executor acceptance; sampled only while `req` = 1.
- `pending`  out  DEPTH_W  registered count of accepted edges not yet acknowledged.
- `overflow`  out  1  sticky; set when an accepted edge is lost at saturation.
- `busy`  out  1  combinational: `req` OR (`pending` ≠ 0).

## Operation
- Reset (async assert, sync-released by the system reset tree): `req`=0, `pending`=0, `overflow`=0, lockout counter=0, FSM=IDLE, so `busy`=0.
- Edge acceptance:
  - An edge is accepted when `edge_in`=1 and the lockout counter is 0.
  - An accepted edge loads the lockout counter with LOCKOUT; if LOCKOUT=0 the counter stays 0.
  - The lockout counter decrements each cycle while nonzero.
  - Rejected edges have no effect.
- Pending update, per cycle, with inc = accepted edge and dec = (FSM=REQ and `ack`=1):
  - inc only: pending+1. If pending is at max, pending holds and `overflow` is set.
  - dec only: pending−1.
  - Both: pending unchanged and no overflow, even at max.
- FSM states:
  - IDLE: `req`=0. Go to REQ when `pending` ≠ 0, including the value registered this cycle.
  - REQ: `req`=1. On `ack`=1 go to IDLE; otherwise stay, holding `req` indefinitely with no timeout.
- One transaction per pending count. `req` always returns low for at least one cycle between transactions.
- `clear`:
  - Highest priority. Next cycle: `pending`=0, `overflow`=0, lockout=0, FSM=IDLE, `req`=0.
  - `edge_in` and `ack` in the clear cycle are discarded.
- `ack` while `req`=0 is ignored.

## Timing
- `edge_in` high in cycle n (accepted, pending was 0): `pending`=1 in n+1, `req`=1 in n+2.
- `ack` high in cycle m with `req`=1: `req`=0 and `pending` decremented in m+1. The earliest next `req` is m+2.
- Lockout: after an edge accepted in cycle n, edges in cycles n+1 … n+LOCKOUT are rejected; an edge in n+LOCKOUT+1 is accepted.
- `overflow` rises the cycle after the lost edge and holds until `clear` or reset.
- Reset asserted mid-transaction: `req` drops asynchronously and the queue is lost. No partial handshake resumes after release.

## Test plan
- Reset, then LOCKOUT=4 and a single `edge_in` pulse at cycle 10, `ack` held 1 → `pending`=1 at 11, `req`=1 at 12, `req`=0 and `pending`=0 at 13, `busy` low from 13.
- LOCKOUT=4, edges at cycles 10,12,14,15, `ack`=0 → only the edges at 10 and 15 are accepted; `pending`=2, `req` stays 1.
- LOCKOUT=0, DEPTH_W=2, 5 consecutive edges, `ack`=0 → `pending` saturates at 3 and `overflow`=1 after the 4th edge. Then issue 3 acks with `req` low between them → `pending`=0, `overflow` still 1. Assert `clear` → `overflow`=0.
- Edge and `ack` in the same cycle with `pending`=3 (max, DEPTH_W=2) → `pending` stays 3, `overflow` stays 0, `req` drops one cycle then reasserts.
- `clear` asserted in a REQ cycle together with `ack`=1 and `edge_in`=1 → next cycle `req`=0, `pending`=0, lockout=0; no further `req` without a new edge.
- Assert `reset_n`=0 asynchronously mid-REQ with `pending`=2 → `req`, `pending`, `overflow`, `busy` go to 0 immediately; they stay 0 after release until a new edge.

Source files
------------

// File: rtl/step_request_queue_if.sv
// Handshake bundle between the edge conditioner/executor side and the step request queue.
// Carries edge pulses, clear and ack inward; req, pending count, overflow and busy outward.
// The queue uses the slave modport; whoever drives edges and acks uses master.
interface step_request_queue_if #(
  parameter int DEPTH_W = 4
);
  logic               edge_in;
  logic               clear;
  logic               ack;
  logic               req;
  logic [DEPTH_W-1:0] pending;
  logic               overflow;
  logic               busy;

  modport master (
    output edge_in, clear, ack,
    input  req, pending, overflow, busy
  );

  modport slave (
    input  edge_in, clear, ack,
    output req, pending, overflow, busy
  );
endinterface

// File: rtl/step_request_queue.sv
// Queues debounced edge pulses and replays each one as a req/ack transaction to the core.
// Latency: edge -> pending next cycle -> req the cycle after; req drops the cycle after ack.
// Backpressure: req is held indefinitely until ack; excess edges count up to a saturating max with sticky overflow.
module step_request_queue #(
  parameter int DEPTH_W   = 4,
  parameter int LOCKOUT   = 1000,
  parameter int LOCKOUT_W = 16
) (
  input logic                clk,
  input logic                reset_n,
  step_request_queue_if.slave bus
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [DEPTH_W-1:0]   PEND_MAX  = '1;
  localparam logic [LOCKOUT_W-1:0] LOCK_LOAD = LOCKOUT_W'(LOCKOUT);

  state_t               state;
  logic                 req_q;
  logic [DEPTH_W-1:0]   pend_q;
  logic                 ovf_q;
  logic [LOCKOUT_W-1:0] lock_cnt;
  logic                 accept;
  logic                 dequeue;

  // An edge only counts when the bounce window from the previous accepted edge has expired.
  assign accept  = bus.edge_in && (lock_cnt == '0);
  // The core consumes one pending entry when it acks an outstanding request.
  assign dequeue = (state == REQ) && bus.ack;

  // Bounce lockout: reload on every accepted edge, count down to zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= '0;
    end else if (bus.clear) begin
      lock_cnt <= '0;
    end else if (accept) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  // Pending count: a simultaneous accept and dequeue cancel out, so no overflow is flagged at max.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.clear) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case ({accept, dequeue})
        2'b10: begin
          if (pend_q == PEND_MAX) begin
            ovf_q <= 1'b1;
          end else begin
            pend_q <= pend_q + 1'b1;
          end
        end
        2'b01:   pend_q <= pend_q - 1'b1;
        default: pend_q <= pend_q;
      endcase
    end
  end

  // Handshake FSM: one req per pending entry, always passing through IDLE between transactions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else if (bus.clear) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_q != '0) begin
            state <= REQ;
            req_q <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req      = req_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = req_q | (pend_q != '0);

endmodule

// File: tb/tb_step_request_queue.sv
// Bench for step_request_queue: two instances (debounced depth-4 and undebounced depth-2)
// driven by directed scenarios then random traffic, checked every cycle against an integer model.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_step_request_queue;

  localparam int A_LOCK = 4;
  localparam int A_MAX  = 15;
  localparam int B_LOCK = 0;
  localparam int B_MAX  = 3;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  // Reference state: remaining lockout cycles, pending count, overflow flag, request outstanding.
  int lk_a, pd_a, lk_b, pd_b;
  bit ov_a, rq_a, ov_b, rq_b;

  step_request_queue_if #(.DEPTH_W(4)) if_a ();
  step_request_queue_if #(.DEPTH_W(2)) if_b ();

  step_request_queue #(.DEPTH_W(4), .LOCKOUT(A_LOCK), .LOCKOUT_W(16)) u_a (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if_a)
  );

  step_request_queue #(.DEPTH_W(2), .LOCKOUT(B_LOCK), .LOCKOUT_W(4)) u_b (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    lk_a = 0; pd_a = 0; ov_a = 0; rq_a = 0;
    lk_b = 0; pd_b = 0; ov_b = 0; rq_b = 0;
  endtask

  // One clock of the queue rules applied to plain integers.
  task automatic model_step(input int lock_len, input int max_p, input bit e, input bit a,
                            input bit c, inout int lk, inout int pd, inout bit ov, inout bit rq);
    bit acc;
    bit deq;
    int pd_old;
    if (c) begin
      lk = 0; pd = 0; ov = 0; rq = 0;
    end else begin
      pd_old = pd;
      acc = e && (lk == 0);
      deq = rq && a;
      if (acc) lk = lock_len;
      else if (lk > 0) lk = lk - 1;
      if (acc && !deq) begin
        if (pd == max_p) ov = 1;
        else pd = pd + 1;
      end else if (deq && !acc) begin
        pd = pd - 1;
      end
      if (rq) rq = !a;
      else rq = (pd_old != 0);
    end
  endtask

  task automatic compare_all();
    check("a_req",  32'(if_a.req),      32'(rq_a));
    check("a_pend", 32'(if_a.pending),  32'(pd_a));
    check("a_ovf",  32'(if_a.overflow), 32'(ov_a));
    check("a_busy", 32'(if_a.busy),     32'(rq_a || (pd_a != 0)));
    check("b_req",  32'(if_b.req),      32'(rq_b));
    check("b_pend", 32'(if_b.pending),  32'(pd_b));
    check("b_ovf",  32'(if_b.overflow), 32'(ov_b));
    check("b_busy", 32'(if_b.busy),     32'(rq_b || (pd_b != 0)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      model_step(A_LOCK, A_MAX, if_a.edge_in, if_a.ack, if_a.clear, lk_a, pd_a, ov_a, rq_a);
      model_step(B_LOCK, B_MAX, if_b.edge_in, if_b.ack, if_b.clear, lk_b, pd_b, ov_b, rq_b);
    end
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    if_a.edge_in = 0; if_a.ack = 0; if_a.clear = 0;
    if_b.edge_in = 0; if_b.ack = 0; if_b.clear = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("rst_req",  32'(if_a.req), 0);
    check("rst_busy", 32'(if_a.busy), 0);

    // Single edge with ack held high.
    if_a.edge_in = 1; if_a.ack = 1;
    tick();
    check("t1_pend1", 32'(if_a.pending), 1);
    check("t1_req0",  32'(if_a.req), 0);
    if_a.edge_in = 0;
    tick();
    check("t1_req1",  32'(if_a.req), 1);
    tick();
    check("t1_req_done",  32'(if_a.req), 0);
    check("t1_pend_done", 32'(if_a.pending), 0);
    check("t1_busy_done", 32'(if_a.busy), 0);
    if_a.ack = 0;
    repeat (6) tick();

    // Bouncing edges: only offsets 0 and 5 clear the 4-cycle lockout.
    for (int i = 0; i < 8; i++) begin
      if_a.edge_in = (i == 0 || i == 2 || i == 4 || i == 5);
      tick();
    end
    if_a.edge_in = 0;
    check("t2_pend", 32'(if_a.pending), 2);
    check("t2_req",  32'(if_a.req), 1);
    if_a.ack = 1;
    repeat (6) tick();
    check("t2_drain", 32'(if_a.pending), 0);
    if_a.ack = 0;
    repeat (6) tick();

    // Clear during REQ with ack and edge also high.
    if_a.edge_in = 1;
    tick();
    if_a.edge_in = 0;
    tick();
    check("t5_req_pre", 32'(if_a.req), 1);
    if_a.edge_in = 1; if_a.ack = 1; if_a.clear = 1;
    tick();
    idle_inputs();
    check("t5_req",  32'(if_a.req), 0);
    check("t5_pend", 32'(if_a.pending), 0);
    tick();
    check("t5_noreq", 32'(if_a.req), 0);
    if_a.edge_in = 1;
    tick();
    check("t5_lock_cleared", 32'(if_a.pending), 1);
    if_a.edge_in = 0; if_a.ack = 1;
    repeat (4) tick();
    if_a.ack = 0;
    repeat (6) tick();

    // Saturation on the depth-2 instance, no lockout.
    for (int i = 1; i <= 5; i++) begin
      if_b.edge_in = 1;
      tick();
      if (i == 3) begin
        check("t3_pend3", 32'(if_b.pending), 3);
        check("t3_ovf0",  32'(if_b.overflow), 0);
      end
      if (i == 4) check("t3_ovf1", 32'(if_b.overflow), 1);
    end
    if_b.edge_in = 0;
    check("t3_pend_sat", 32'(if_b.pending), 3);
    if_b.ack = 1;
    repeat (6) tick();
    check("t3_pend0",   32'(if_b.pending), 0);
    check("t3_ovf_hold", 32'(if_b.overflow), 1);
    check("t3_req0",    32'(if_b.req), 0);
    if_b.ack = 0; if_b.clear = 1;
    tick();
    if_b.clear = 0;
    check("t3_ovf_clr", 32'(if_b.overflow), 0);

    // Edge and ack together at max.
    if_b.edge_in = 1;
    repeat (3) tick();
    if_b.edge_in = 0;
    tick();
    check("t4_pend_pre", 32'(if_b.pending), 3);
    check("t4_req_pre",  32'(if_b.req), 1);
    if_b.edge_in = 1; if_b.ack = 1;
    tick();
    check("t4_pend", 32'(if_b.pending), 3);
    check("t4_ovf",  32'(if_b.overflow), 0);
    check("t4_req_drop", 32'(if_b.req), 0);
    if_b.edge_in = 0; if_b.ack = 0;
    tick();
    check("t4_req_again", 32'(if_b.req), 1);
    if_b.clear = 1;
    tick();
    if_b.clear = 0;

    // Async reset mid-REQ with two pending on A and an overflowed B.
    if_a.edge_in = 1; if_b.edge_in = 1;
    tick();
    if_a.edge_in = 0;
    repeat (3) tick();
    if_b.edge_in = 0;
    repeat (2) tick();
    if_a.edge_in = 1;
    tick();
    if_a.edge_in = 0;
    tick();
    check("t6_pend_pre", 32'(if_a.pending), 2);
    check("t6_req_pre",  32'(if_a.req), 1);
    check("t6_bovf_pre", 32'(if_b.overflow), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_req_async",  32'(if_a.req), 0);
    check("t6_pend_async", 32'(if_a.pending), 0);
    check("t6_busy_async", 32'(if_a.busy), 0);
    check("t6_bovf_async", 32'(if_b.overflow), 0);
    compare_all();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_req_after",  32'(if_a.req), 0);
    check("t6_pend_after", 32'(if_a.pending), 0);

    // Random traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      if_a.edge_in = ($urandom_range(0, 9) < 3);
      if_a.ack     = ($urandom_range(0, 9) < 4);
      if_a.clear   = ($urandom_range(0, 99) == 0);
      if_b.edge_in = ($urandom_range(0, 9) < 5);
      if_b.ack     = ($urandom_range(0, 9) < 3);
      if_b.clear   = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
